// File: rtl/mem_axi_pkg.sv
// mem_axi_pkg: shared AXI burst/response encodings, FSM states and helpers for the AXI memory slave
package mem_axi_pkg;
  typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10, BURST_RSVD = 2'b11} burst_t;
  typedef enum logic [1:0] {S_RST, S_IDLE, S_BURST} state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/mem_axi_read_responder_if.sv
// mem_axi_read_responder_if: AXI read channels plus RAM read port, with master and slave views
interface mem_axi_read_responder_if #(
  parameter int WIDTH_ID = 4,
  parameter int WIDTH_AD = 10,
  parameter int WIDTH_DA = 32
);
  localparam int WIDTH_DS = WIDTH_DA / 8;
  logic [WIDTH_ID-1:0] ARID;
  logic [WIDTH_AD-1:0] ARADDR;
  logic [7:0]          ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;
  logic [WIDTH_ID-1:0] RID;
  logic [WIDTH_DA-1:0] RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;
  logic [WIDTH_AD-1:0] MEM_RADDR;
  logic [WIDTH_DS-1:0] MEM_RSTRB;
  logic                MEM_REN;
  logic [WIDTH_DA-1:0] MEM_RDATA;
  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY, MEM_RDATA,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID, MEM_RADDR, MEM_RSTRB, MEM_REN
  );
  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY, MEM_RDATA,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID, MEM_RADDR, MEM_RSTRB, MEM_REN
  );
endinterface

// File: rtl/mem_axi_read_fifo2.sv
// mem_axi_read_fifo2: two-entry buffer holding {last, resp, data} beats awaiting RREADY
module mem_axi_read_fifo2 #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic rd, wr;
  assign dout = mem[rd];
  // store pushed beats and advance pointers; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd     <= 1'b0;
      wr     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr      <= ~wr;
      end
      if (pop) rd <= ~rd;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/mem_axi_read_responder.sv
// mem_axi_read_responder: AXI4 read responder issuing per-beat RAM reads into a 2-entry credit buffer
module mem_axi_read_responder
  import mem_axi_pkg::*;
#(
  parameter int WIDTH_ID = 4,
  parameter int WIDTH_AD = 10,
  parameter int WIDTH_DA = 32
) (
  input logic CLK,
  input logic RESETn,
  mem_axi_read_responder_if.slave bus
);
  localparam int WIDTH_DS  = WIDTH_DA / 8;
  localparam int WIDTH_DSB = clogb2(WIDTH_DS);
  localparam logic [WIDTH_DS-1:0] ONES = '1;
  state_t              state, state_nx;
  logic [WIDTH_ID-1:0] id;
  logic [WIDTH_AD-1:0] addr, addr_nx, nb, aligned, wmask;
  logic [7:0]          len;
  logic [2:0]          size;
  burst_t              burst;
  logic                err, ar_err, inflight, tag_last;
  logic [8:0]          beats_left;
  logic                ar_hs, pop, push, issue, credit;
  logic [1:0]          count;
  logic [WIDTH_DA+2:0] fifo_din, fifo_dout;
  logic [WIDTH_DS-1:0] strb;
  int                  lane, nbi;
  assign ar_hs  = bus.ARVALID & bus.ARREADY;
  assign pop    = bus.RVALID & bus.RREADY;
  assign credit = ({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
  assign issue  = (state == S_BURST) && (beats_left != 9'd0) && credit;
  assign push   = inflight | (issue & err);
  assign ar_err = (bus.ARSIZE > 3'(WIDTH_DSB)) || (bus.ARBURST == BURST_RSVD) ||
                  ((bus.ARBURST == BURST_WRAP) && !(bus.ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15}));
  assign fifo_din = inflight ? {tag_last, RESP_OKAY, bus.MEM_RDATA}
                             : {beats_left == 9'd1, RESP_SLVERR, {WIDTH_DA{1'b0}}};
  assign bus.MEM_REN   = issue & ~err;
  assign bus.MEM_RADDR = addr;
  assign bus.MEM_RSTRB = bus.MEM_REN ? strb : '0;
  assign bus.RVALID    = count != 2'd0;
  assign bus.RID       = id;
  assign {bus.RLAST, bus.RRESP, bus.RDATA} = fifo_dout;
  // state register; reset parks in S_RST so ARREADY stays low until the first clock after release
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= S_RST;
    else state <= state_nx;
  end
  // next state: accept one burst in IDLE, return after the RLAST beat is handshaken
  always_comb begin
    bus.ARREADY = state == S_IDLE;
    state_nx = state == S_RST  ? S_IDLE :
               state == S_IDLE ? (bus.ARVALID ? S_BURST : S_IDLE) :
               (pop && bus.RLAST) ? S_IDLE : S_BURST;
  end
  // next beat address: FIXED holds, INCR steps from the aligned address, WRAP stays inside its window
  always_comb begin
    nb      = WIDTH_AD'(1) << size;
    aligned = addr & ~(nb - WIDTH_AD'(1));
    wmask   = ((WIDTH_AD'(len) + WIDTH_AD'(1)) << size) - WIDTH_AD'(1);
    addr_nx = burst == BURST_INCR ? aligned + nb :
              burst == BURST_WRAP ? (addr & ~wmask) | ((aligned + nb) & wmask) : addr;
  end
  // lane enables: a 2^size window at the aligned lane, trimmed below addr for an unaligned INCR start
  always_comb begin
    lane = int'(addr) % WIDTH_DS;
    nbi  = 1 << size;
    strb = (ONES >> (WIDTH_DS - nbi)) << (lane & ~(nbi - 1));
    strb = burst == BURST_INCR ? strb & (ONES << lane) : strb;
  end
  // burst context latch, per-beat address/count update and tagging of the read in flight
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      id         <= '0;
      addr       <= '0;
      len        <= 8'd0;
      size       <= 3'd0;
      burst      <= BURST_FIXED;
      err        <= 1'b0;
      beats_left <= 9'd0;
      inflight   <= 1'b0;
      tag_last   <= 1'b0;
    end else begin
      inflight <= bus.MEM_REN;
      tag_last <= beats_left == 9'd1;
      if (ar_hs) begin
        id         <= bus.ARID;
        addr       <= bus.ARADDR;
        len        <= bus.ARLEN;
        size       <= bus.ARSIZE;
        burst      <= burst_t'(bus.ARBURST);
        err        <= ar_err;
        beats_left <= {1'b0, bus.ARLEN} + 9'd1;
      end else if (issue) begin
        addr       <= addr_nx;
        beats_left <= beats_left - 9'd1;
      end
    end
  end
  mem_axi_read_fifo2 #(.W(WIDTH_DA + 3)) u_fifo (
    .clk   (CLK),
    .rst_n (RESETn),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (count)
  );
endmodule

// File: tb/tb_mem_axi_read_responder.sv
// tb_mem_axi_read_responder: scoreboard bench with directed AXI read bursts against a byte-pattern RAM
module tb_mem_axi_read_responder;
  import mem_axi_pkg::*;
  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id;} beat_t;
  typedef struct packed {logic [9:0] addr; logic [3:0] strb;} req_t;
  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  beat_t exp_q[$];
  req_t  req_q[$];
  int tests = 0, fails = 0;
  int n_iss = 0, n_pop = 0, max_out = 0, pops = 0;
  int rr_mode = 0, rr_ph = 0;
  logic [31:0] ram_word;
  logic [3:0] ren_vec, rv_vec;
  always #5 CLK = ~CLK;
  mem_axi_read_responder_if bus ();
  mem_axi_read_responder dut (.CLK(CLK), .RESETn(RESETn), .bus(bus));
  // RAM model: byte at address a holds a[7:0]; disabled lanes read 0, idle cycles return garbage
  always @(posedge CLK) begin
    if (bus.MEM_REN) begin
      for (int l = 0; l < 4; l++) ram_word[8*l +: 8] = bus.MEM_RSTRB[l] ? {bus.MEM_RADDR[7:2], 2'(l)} : 8'h00;
      bus.MEM_RDATA <= ram_word;
    end else bus.MEM_RDATA <= 32'hDEADBEEF;
  end
  // RREADY driver: always high, or a 1,0,0 pattern when back-pressure is wanted
  always @(posedge CLK) begin
    #1;
    rr_ph = rr_ph + 1;
    bus.RREADY = (rr_mode == 0) ? 1'b1 : (rr_ph % 3 == 0);
  end
  // monitor: checks RAM requests and every presented R beat against the scoreboard
  always @(negedge CLK) begin
    if (RESETn) begin
      if (n_iss - n_pop > max_out) max_out = n_iss - n_pop;
      if (bus.MEM_REN) begin
        req_t r;
        n_iss++;
        tests++;
        if (req_q.size() == 0) begin
          fails++;
          $display("FAIL ren_unexpected addr=%h strb=%b required no read", bus.MEM_RADDR, bus.MEM_RSTRB);
        end else begin
          r = req_q.pop_front();
          if (bus.MEM_RADDR !== r.addr || bus.MEM_RSTRB !== r.strb) begin
            fails++;
            $display("FAIL mem_req addr=%h strb=%b required addr=%h strb=%b", bus.MEM_RADDR, bus.MEM_RSTRB, r.addr, r.strb);
          end
        end
      end
      if (bus.RVALID) begin
        beat_t a;
        a = '{data: bus.RDATA, resp: bus.RRESP, last: bus.RLAST, id: bus.RID};
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL r_unexpected got data=%h resp=%b last=%b id=%h required no beat", a.data, a.resp, a.last, a.id);
        end else begin
          if (a !== exp_q[0]) begin
            fails++;
            $display("FAIL r_beat got data=%h resp=%b last=%b id=%h required data=%h resp=%b last=%b id=%h",
                     a.data, a.resp, a.last, a.id, exp_q[0].data, exp_q[0].resp, exp_q[0].last, exp_q[0].id);
          end
          if (bus.RREADY) begin
            void'(exp_q.pop_front());
            n_pop++;
            pops++;
          end
        end
      end
    end
  end
  task automatic add_beat(input logic [31:0] d, input logic [1:0] rs, input logic l, input logic [3:0] i);
    exp_q.push_back('{data: d, resp: rs, last: l, id: i});
  endtask
  task automatic add_req(input logic [9:0] a, input logic [3:0] s);
    req_q.push_back('{addr: a, strb: s});
  endtask
  task automatic send(input logic [3:0] i, input logic [9:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    int n;
    @(negedge CLK);
    bus.ARID = i; bus.ARADDR = a; bus.ARLEN = l; bus.ARSIZE = s; bus.ARBURST = b; bus.ARVALID = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (!bus.ARREADY) begin
      fails++;
      $display("FAIL arready_timeout got 0 required 1 within 50 cycles");
    end
    @(posedge CLK);
    #1 bus.ARVALID = 1'b0;
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || req_q.size() != 0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (exp_q.size() != 0 || req_q.size() != 0) begin
      fails++;
      $display("FAIL burst_timeout got %0d beats %0d reqs pending required 0", exp_q.size(), req_q.size());
    end
    repeat (2) @(negedge CLK);
  endtask
  task automatic check_zero(input string nm);
    logic [63:0] v;
    v = {bus.ARREADY, bus.RVALID, bus.RLAST, bus.MEM_REN, bus.RRESP, bus.RID, bus.RDATA, bus.MEM_RADDR, bus.MEM_RSTRB};
    tests++;
    if (v !== 64'd0) begin
      fails++;
      $display("FAIL %s outputs got %h required 0", nm, v);
    end
  endtask
  initial begin
    bus.ARVALID = 1'b0; bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
    bus.RREADY = 1'b1;
    repeat (3) @(negedge CLK);
    check_zero("reset");
    RESETn = 1'b1;
    // INCR 0x10, 4 beats, with latency and back-to-back issue checks
    add_req(10'h10, 4'hF); add_req(10'h14, 4'hF); add_req(10'h18, 4'hF); add_req(10'h1C, 4'hF);
    add_beat(32'h13121110, 2'b00, 1'b0, 4'h3); add_beat(32'h17161514, 2'b00, 1'b0, 4'h3);
    add_beat(32'h1B1A1918, 2'b00, 1'b0, 4'h3); add_beat(32'h1F1E1D1C, 2'b00, 1'b1, 4'h3);
    send(4'h3, 10'h10, 8'd3, 3'd2, 2'b01);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      ren_vec = {ren_vec[2:0], bus.MEM_REN};
      rv_vec  = {rv_vec[2:0], bus.RVALID};
    end
    tests++;
    if (ren_vec !== 4'b1111) begin fails++; $display("FAIL ren_cycles1to4 got %b required 1111", ren_vec); end
    tests++;
    if (rv_vec !== 4'b0011) begin fails++; $display("FAIL rvalid_cycles1to4 got %b required 0011", rv_vec); end
    wait_done();
    // WRAP 0x38 over a 16-byte window
    add_req(10'h38, 4'hF); add_req(10'h3C, 4'hF); add_req(10'h30, 4'hF); add_req(10'h34, 4'hF);
    add_beat(32'h3B3A3938, 2'b00, 1'b0, 4'h5); add_beat(32'h3F3E3D3C, 2'b00, 1'b0, 4'h5);
    add_beat(32'h33323130, 2'b00, 1'b0, 4'h5); add_beat(32'h37363534, 2'b00, 1'b1, 4'h5);
    send(4'h5, 10'h38, 8'd3, 3'd2, 2'b10);
    wait_done();
    // narrow FIXED byte reads at 0x21
    for (int i = 0; i < 3; i++) begin
      add_req(10'h21, 4'b0010);
      add_beat(32'h00002100, 2'b00, i == 2, 4'h7);
    end
    send(4'h7, 10'h21, 8'd2, 3'd0, 2'b00);
    wait_done();
    // unaligned INCR start trims the low lanes on the first beat only
    add_req(10'h12, 4'b1100); add_req(10'h14, 4'hF);
    add_beat(32'h13120000, 2'b00, 1'b0, 4'h2); add_beat(32'h17161514, 2'b00, 1'b1, 4'h2);
    send(4'h2, 10'h12, 8'd1, 3'd2, 2'b01);
    wait_done();
    // INCR 8 beats under RREADY back-pressure
    n_iss = 0; n_pop = 0; max_out = 0; pops = 0;
    rr_mode = 1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a;
      a = 8'h40 + 8'(4 * i);
      add_req({2'b00, a}, 4'hF);
      add_beat({a + 8'd3, a + 8'd2, a + 8'd1, a}, 2'b00, i == 7, 4'h1);
    end
    send(4'h1, 10'h40, 8'd7, 3'd2, 2'b01);
    wait_done();
    rr_mode = 0;
    tests++;
    if (max_out > 2) begin fails++; $display("FAIL buffered_max got %0d required <=2", max_out); end
    tests++;
    if (pops != 8) begin fails++; $display("FAIL beat_count got %0d required 8", pops); end
    // oversized ARSIZE: two SLVERR beats, no RAM reads
    add_beat(32'h0, 2'b10, 1'b0, 4'h6); add_beat(32'h0, 2'b10, 1'b1, 4'h6);
    send(4'h6, 10'h00, 8'd1, 3'd3, 2'b01);
    wait_done();
    // reset after the second beat of an 8-beat burst, then a fresh single beat
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a;
      a = 8'h80 + 8'(4 * i);
      add_req({2'b00, a}, 4'hF);
      add_beat({a + 8'd3, a + 8'd2, a + 8'd1, a}, 2'b00, i == 7, 4'h4);
    end
    send(4'h4, 10'h80, 8'd7, 3'd2, 2'b01);
    for (int n = 0; n < 50 && pops < 2; n++) @(negedge CLK);
    tests++;
    if (pops < 2) begin fails++; $display("FAIL reset_prep got %0d beats required 2", pops); end
    @(posedge CLK);
    #2 RESETn = 1'b0;
    #1 check_zero("midburst_reset");
    exp_q.delete();
    req_q.delete();
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    repeat (4) @(negedge CLK);
    add_req(10'h64, 4'hF);
    add_beat(32'h67666564, 2'b00, 1'b1, 4'h9);
    send(4'h9, 10'h64, 8'd0, 3'd2, 2'b01);
    wait_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_axi_read_responder.md
Name: mem_axi_read_responder

Overview:
- AXI4 read-channel responder. Sits between an AXI read master (AR/R channels) and the read port of the byte-laned synchronous dual-port RAM (one-cycle read latency, per-byte read strobes).
- Accepts one burst at a time, generates per-beat RAM read addresses and byte strobes, and returns data through a 2-entry output buffer so RREADY back-pressure never loses RAM data.
- Companion to the write-side responder; together they form the AXI memory slave.

Parameters:
WIDTH_ID, 4, AXI ID width
WIDTH_AD, 10, byte-address width (memory size = 1<<WIDTH_AD bytes)
WIDTH_DA, 32, data width in bits (8..1024, power of 2)
WIDTH_DS, WIDTH_DA/8, byte lanes
WIDTH_DSB, clogb2(WIDTH_DS), lane-index bits

Ports:
CLK  input  1  clock
RESETn  input  1  asynchronous active-low reset
ARID  input  WIDTH_ID  burst ID
ARADDR  input  WIDTH_AD  start byte address
ARLEN  input  8  beats-1
ARSIZE  input  3  log2 bytes per beat
ARBURST  input  2  00 FIXED, 01 INCR, 10 WRAP
ARVALID  input  1  address valid
ARREADY  output  1  address accept
RID  output  WIDTH_ID  echoed ARID
RDATA  output  WIDTH_DA  read data
RRESP  output  2  00 OKAY, 10 SLVERR
RLAST  output  1  final beat
RVALID  output  1  data valid
RREADY  input  1  data accept
MEM_RADDR  output  WIDTH_AD  RAM byte address (RAM drops low WIDTH_DSB bits)
MEM_RSTRB  output  WIDTH_DS  RAM lane enables
MEM_REN  output  1  RAM read enable
MEM_RDATA  input  WIDTH_DA  RAM data, valid the cycle after MEM_REN

Behaviour:
- Reset: all outputs 0. FSM to IDLE. Buffer empty, in-flight flag clear.
- FSM IDLE:
  - ARREADY=1.
  - On ARVALID&ARREADY, latch ID/addr/len/size/burst, set beats_left=ARLEN+1, go to BURST.
- FSM BURST:
  - ARREADY=0.
  - Return to IDLE on the cycle the beat with RLAST is handshaken; ARREADY rises the next cycle.
- Issue rule: MEM_REN=1 when beats_left>0 and (count + inflight - pop) < 2.
  - count: buffer occupancy, 0..2.
  - inflight: MEM_REN registered from the previous cycle.
  - pop: RVALID&RREADY.
- Capture: when inflight=1, MEM_RDATA is written into the buffer together with RLAST/RRESP tags computed at issue. MEM_RDATA is ignored otherwise, because it may be X.
- RVALID = count>0. RDATA/RID/RRESP/RLAST come from the buffer head and are held stable while RVALID&!RREADY.
- Latency: AR handshake at edge 0 → MEM_REN in cycle 1 → RVALID in cycle 3.
- Throughput: with RREADY held high, one beat per cycle after the first.
- Address update per issued beat:
  - FIXED: unchanged.
  - INCR: (addr & ~(2^size-1)) + 2^size. Wraps modulo 2^WIDTH_AD, no error.
  - WRAP: increment within the boundary aligned to (ARLEN+1)*2^size.
- MEM_RSTRB: lanes addr[WIDTH_DSB-1:size] aligned, 2^size wide. The first beat of an unaligned INCR masks the lanes below addr.
- SLVERR bursts: ARSIZE>WIDTH_DSB, or WRAP with ARLEN not in {1,3,7,15}, or ARBURST=11.
  - All beats are returned with RRESP=10 and RDATA=0.
  - MEM_REN stays 0; the buffer is filled directly, respecting the same credit rule.
- RLAST=1 only on beat ARLEN+1. Single-beat bursts (ARLEN=0) have RLAST on the first beat.
- Simultaneous push and pop: count unchanged.
- Reset mid-burst: the burst is abandoned and no further beats are produced.

Decomposition:
- Shared package (mem_axi_pkg): burst encodings (FIXED/INCR/WRAP), RRESP codes, clogb2 function.
- One sub-module, mem_axi_read_fifo2: 2-entry buffer of {RLAST, RRESP, RDATA} with push/pop/count; RID comes from the latched ID register.
- Address/strobe generation stays in the top module.

Test Plan:
- INCR, ARADDR=0x10, ARLEN=3, ARSIZE=2, RREADY=1 → MEM_RADDR 0x10,0x14,0x18,0x1C on consecutive cycles; 4 beats OKAY; RLAST on 4th; RVALID first in cycle 3 after AR.
- WRAP, ARADDR=0x38, ARLEN=3, ARSIZE=2 → addresses 0x38,0x3C,0x30,0x34; data matches RAM preload.
- Narrow FIXED, ARADDR=0x21, ARSIZE=0, ARLEN=2 → MEM_RSTRB=0010 on every beat, MEM_RADDR=0x21 every beat.
- INCR ARLEN=7 with RREADY toggling 1,0,0,1,… → no beat lost or duplicated, at most 2 beats buffered, RDATA stable while stalled.
- ARSIZE=3 on 32-bit bus, ARLEN=1 → 2 beats RRESP=10, RDATA=0, MEM_REN never asserted.
- RESETn low after beat 2 of ARLEN=7 → all outputs 0 immediately; after release ARREADY=1 and a new ARLEN=0 burst completes normally.
